// File: rtl/seq_alu_if.sv
// Request/response bundle between the decode stage (master) and seq_alu (slave).
// Each side transfers on a rising edge where its valid and ready are both high; valid never waits on ready.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic             illegal_op;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero, overflow, div_by_zero, illegal_op
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero, overflow, div_by_zero, illegal_op
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one operation at a time, single-cycle logic ops, shift-add MUL, restoring DIV.
// Define ALU_DIV_EN to build the divider; without it opcode 0011 completes as an illegal op.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b0011;
`endif
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] mcand, mul_hi, mul_lo;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   mul_sum;

    logic             start_iter, load_res;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d, dbz_d, ill_d;

    logic [WIDTH-1:0] add_r, sub_r;
    logic             add_ovf, sub_ovf;
    logic [SHW-1:0]   shamt;

    assign add_r   = bus.a + bus.b;
    assign sub_r   = bus.a - bus.b;
    assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
    assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
    assign shamt   = bus.b[SHW-1:0];

    // Shift-add step: the multiplier drains out of mul_lo while product bits fill in from the top.
    assign mul_sum  = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], mul_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic             is_div;
    logic [WIDTH-1:0] div_d, div_r, div_q;
    logic [WIDTH-1:0] div_r_n, div_q_n, rem_diff;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;

    // Restoring step; a zero divisor always "fits", so the quotient saturates to all-ones.
    assign rem_sh   = {div_r, div_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, div_d};
    assign rem_diff = rem_sh[WIDTH-1:0] - div_d;
    assign div_r_n  = div_ge ? rem_diff : rem_sh[WIDTH-1:0];
    assign div_q_n  = {div_q[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_iter = 1'b0;
        load_res   = 1'b0;
        res_d      = '0;
        ovf_d      = 1'b0;
        dbz_d      = 1'b0;
        ill_d      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = DONE;
                    load_res   = 1'b1;
                    case (bus.alu_op)
                        OP_ADD: begin
                            res_d = add_r;
                            ovf_d = add_ovf;
                        end
                        OP_SUB: begin
                            res_d = sub_r;
                            ovf_d = sub_ovf;
                        end
                        OP_MUL: begin
                            state_next = BUSY;
                            load_res   = 1'b0;
                            start_iter = 1'b1;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            state_next = BUSY;
                            load_res   = 1'b0;
                            start_iter = 1'b1;
                        end
`endif
                        OP_AND: res_d = bus.a & bus.b;
                        OP_OR:  res_d = bus.a | bus.b;
                        OP_XOR: res_d = bus.a ^ bus.b;
                        OP_SLL: res_d = bus.a << shamt;
                        OP_SRL: res_d = bus.a >> shamt;
                        OP_ASR: res_d = WIDTH'($signed(bus.a) >>> shamt);
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            BUSY: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    load_res   = 1'b1;
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        res_d = div_q_n;
                        dbz_d = (div_d == '0);
                    end else begin
                        res_d = mul_lo_n;
                        ovf_d = |mul_hi_n;
                    end
`else
                    res_d = mul_lo_n;
                    ovf_d = |mul_hi_n;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            mcand           <= '0;
            mul_hi          <= '0;
            mul_lo          <= '0;
`ifdef ALU_DIV_EN
            is_div          <= 1'b0;
            div_d           <= '0;
            div_r           <= '0;
            div_q           <= '0;
`endif
            bus.result      <= '0;
            bus.zero        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.illegal_op  <= 1'b0;
        end else begin
            if (start_iter) begin
                cnt    <= CNT_INIT;
                mcand  <= bus.a;
                mul_hi <= '0;
                mul_lo <= bus.b;
`ifdef ALU_DIV_EN
                is_div <= (bus.alu_op == OP_DIV);
                div_d  <= bus.b;
                div_r  <= '0;
                div_q  <= bus.a;
`endif
            end else if (state == BUSY) begin
                cnt    <= cnt - 1'b1;
                mul_hi <= mul_hi_n;
                mul_lo <= mul_lo_n;
`ifdef ALU_DIV_EN
                div_r  <= div_r_n;
                div_q  <= div_q_n;
`endif
            end
            if (load_res) begin
                bus.result      <= res_d;
                bus.zero        <= (res_d == '0);
                bus.overflow    <= ovf_d;
                bus.div_by_zero <= dbz_d;
                bus.illegal_op  <= ill_d;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign dbg_state     = state;
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the combinational 32-bit ALU. It keeps the same 4-bit opcode map and the Zero/Overflow flags. It adds:
- a registered valid/ready handshake on both sides;
- iterative multiply and divide;
- divide-by-zero and illegal-opcode flags.

It sits between the decode stage and writeback and accepts one operation at a time.

## Interface
- WIDTH, 32: operand and result width. Must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b[SHW-1:0].
- alu_op  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  result equals 0.
- overflow  out  1  see Operation.
- div_by_zero  out  1  DIV with b == 0.
- illegal_op  out  1  unmapped opcode.

## Operation
Opcode map:
- 0000 ADD
- 0001 SUB
- 0010 MUL: low WIDTH bits of the unsigned product.
- 0011 DIV: unsigned quotient.
- 0100 AND, 0101 OR, 0110 XOR
- 0111 SLL, 1000 SRL, 1001 ASR
- 1010–1111: illegal.

State machine (IDLE, BUSY, DONE):
- IDLE:
  - in_ready = 1.
  - On in_valid: capture a, b, alu_op.
  - Single-cycle ops and illegal opcodes: compute and register result and flags, then go to DONE.
  - MUL/DIV: load the iteration counter with WIDTH, then go to BUSY.
- BUSY:
  - One iteration per cycle: shift-add for MUL, restoring shift-subtract for DIV.
  - Counter decrements each cycle; at counter == 1, register result and flags and go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid = 1; result and flags are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored.

Flags:
- overflow:
  - ADD/SUB: signed two's-complement overflow.
  - MUL: upper WIDTH bits of the full unsigned 2*WIDTH product are nonzero.
  - All other ops: 0.
- zero: (result == 0), for every op including illegal.
- div_by_zero:
  - DIV with b == 0 takes the full WIDTH iterations.
  - Result is all-ones, div_by_zero = 1, overflow = 0.
  - div_by_zero is 0 for every other op.
- illegal_op: result = 0, zero = 1, illegal_op = 1, all other flags 0.

Shifts:
- Use b[SHW-1:0] only; upper bits of b are ignored.
- ASR replicates a[WIDTH-1].

## Timing
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - result = 0, zero = 0, overflow = 0, div_by_zero = 0, illegal_op = 0, out_valid = 0.
  - in_ready is decoded from state, so it is 1 during and after reset.
- Acceptance happens on the edge where in_valid && in_ready.
- Single-cycle ops: out_valid rises 1 cycle after the acceptance edge.
- MUL/DIV: out_valid rises WIDTH+1 cycles after the acceptance edge (33 for WIDTH = 32).
- Result transfer happens on the edge where out_valid && out_ready.
  - out_valid falls and in_ready rises on that edge.
  - The next request can be accepted no earlier than the following edge.
  - Peak throughput is one single-cycle op per 2 cycles.
- Holding out_ready low keeps the DONE state with result and flags unchanged, indefinitely.
- Asserting rst_n low mid-BUSY or in DONE aborts the operation. No partial result is ever presented.
- Outputs are registered. No combinational path from in_valid, a, b or out_ready to any output except in_ready.

## Configuration
ALU_DIV_EN:
- Defined: the DIV datapath (divisor, remainder and quotient registers) is compiled in, and 0011 behaves as above.
- Undefined: no divider hardware is built, and 0011 is treated as illegal. It completes in 1 cycle with result = 0, illegal_op = 1, div_by_zero = 0.

## Test plan
All scenarios use WIDTH = 32 and ALU_DIV_EN defined unless stated otherwise.
- ADD a=45, b=23 -> result 68, zero 0, overflow 0, out_valid exactly 1 cycle after acceptance. Repeat with SUB -> 22. Repeat with AND/OR/XOR -> 5 / 63 / 58.
- SUB a=0x7FFFFFFF, b=0xFFFFFFFF -> result 0x80000000, overflow 1. ADD a=0xFFFFFFFF, b=1 -> result 0, zero 1, overflow 0.
- MUL a=45, b=23 -> 1035 after 33 cycles, overflow 0. MUL a=0x10000, b=0x10000 -> result 0, zero 1, overflow 1. in_valid held high during BUSY is not accepted.
- DIV a=45, b=23 -> 1. DIV a=45, b=0 -> 0xFFFFFFFF, div_by_zero 1, after 33 cycles. Rebuilt without ALU_DIV_EN: DIV -> result 0, illegal_op 1, after 1 cycle.
- SLL a=45, b=2 -> 180. SRL a=45, b=2 -> 11. ASR a=-45, b=2 -> 0xFFFFFFF4. SLL a=1, b=0x21 -> 2 (amount masked to 1). Opcode 1100 -> result 0, illegal_op 1, zero 1.
- Backpressure and reset:
  - out_ready low for 5 cycles after out_valid: result stable, in_ready 0, no new acceptance.
  - rst_n pulsed low at cycle 10 of a MUL: out_valid 0, in_ready 1, all outputs 0. A subsequent ADD 1+1 returns 2 with correct latency.
